// File: rtl/demux32_1x2_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : demux32_1x2_pipe_pkg
// Brief    : Shared select encodings and slot state type for the 1x2 demux.
// Revision : 1.0 - initial release
// ============================================================================
package demux32_1x2_pipe_pkg;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

endpackage
`default_nettype wire

// File: rtl/demux32_1x2_pipe_demux_slot.sv
`default_nettype none
// ============================================================================
// Module   : demux32_1x2_pipe_demux_slot
// Brief    : One-entry output register slice with valid/ready and a
//            wrapping transfer counter.
// Revision : 1.0 - initial release
// ============================================================================
module demux32_1x2_pipe_demux_slot
    import demux32_1x2_pipe_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic             o_can_accept,
    output logic [CNT_W-1:0] o_cnt
);

    slot_state_t      r_state;
    slot_state_t      w_state_next;
    logic [WIDTH-1:0] r_data;
    logic [CNT_W-1:0] r_cnt;
    logic             w_drain;

    assign w_drain      = (r_state == SLOT_FULL) && i_ready;
    assign o_valid      = (r_state == SLOT_FULL);
    assign o_data       = r_data;
    assign o_cnt        = r_cnt;
    // Room exists when empty or when the held word leaves this same cycle.
    assign o_can_accept = (r_state == SLOT_EMPTY) || i_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= SLOT_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            SLOT_EMPTY: begin
                if (i_load) begin
                    w_state_next = SLOT_FULL;
                end
            end
            SLOT_FULL: begin
                if (w_drain && !i_load) begin
                    w_state_next = SLOT_EMPTY;
                end
            end
            default: w_state_next = SLOT_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= '0;
        end else if (i_load) begin
            r_data <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_drain) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/demux32_1x2_pipe.sv
`default_nettype none
// ============================================================================
// Module   : demux32_1x2_pipe
// Brief    : Registered 1-to-2 demultiplexer steering each word to A or B.
// Revision : 1.0 - initial release
// ============================================================================
module demux32_1x2_pipe
    import demux32_1x2_pipe_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] a_data,
    output logic             b_valid,
    input  logic             b_ready,
    output logic [WIDTH-1:0] b_data,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b
);

    logic w_sel_a;
    logic w_sel_b;
    logic w_accept;
    logic w_room_a;
    logic w_room_b;
    logic w_load_a;
    logic w_load_b;

    assign w_sel_a  = (in_sel == SEL_A);
    assign w_sel_b  = (in_sel == SEL_B);
    // Only the selected slot gates the source, so a stalled B never blocks A.
    assign in_ready = w_sel_b ? w_room_b : w_room_a;
    assign w_accept = in_valid && in_ready;
    assign w_load_a = w_accept && w_sel_a;
    assign w_load_b = w_accept && w_sel_b;

    demux32_1x2_pipe_demux_slot #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_slot_a (
        .clk          (clk),
        .rst          (rst),
        .i_load       (w_load_a),
        .i_data       (in_data),
        .i_ready      (a_ready),
        .o_valid      (a_valid),
        .o_data       (a_data),
        .o_can_accept (w_room_a),
        .o_cnt        (cnt_a)
    );

    demux32_1x2_pipe_demux_slot #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_slot_b (
        .clk          (clk),
        .rst          (rst),
        .i_load       (w_load_b),
        .i_data       (in_data),
        .i_ready      (b_ready),
        .o_valid      (b_valid),
        .o_data       (b_data),
        .o_can_accept (w_room_b),
        .o_cnt        (cnt_b)
    );

endmodule
`default_nettype wire

// File: doc/demux32_1x2_pipe.md
Name: demux32_1x2_pipe

Overview:
- Registered 1-to-2 demultiplexer for 32-bit words with valid/ready handshakes on every side.
- Performs the inverse of the datapath 2x1 mux: one source stream is steered per word to destination A (sel=0) or B (sel=1).
- Used on the CPU store path to route write data to data memory (A) or the I/O/peripheral bus (B).
- Each destination has a one-entry output register so that back-pressure on one destination does not corrupt in-flight data on the other. Each destination also has a transfer counter for debug.

Parameters:
- WIDTH, 32, data word width in bits.
- CNT_W, 16, width of each per-destination transfer counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  source presents a word.
- in_ready  out  1  block accepts the word this cycle.
- in_data  in  WIDTH  source word.
- in_sel  in  1  destination select: 0 = A, 1 = B. Sampled with in_data.
- a_valid  out  1  output register A holds a word.
- a_ready  in  1  destination A consumes the word.
- a_data  out  WIDTH  word for A.
- b_valid  out  1  output register B holds a word.
- b_ready  in  1  destination B consumes the word.
- b_data  out  WIDTH  word for B.
- cnt_a  out  CNT_W  number of words delivered to A (counted on a_valid & a_ready).
- cnt_b  out  CNT_W  number of words delivered to B.

Behaviour:
- Reset (rst=1 at a clock edge): a_valid=0, b_valid=0, a_data=0, b_data=0, cnt_a=0, cnt_b=0. in_ready is combinational and follows the slot state; with both slots empty after reset it is 1. Reset overrides any handshake in the same cycle; a word presented during reset is dropped.
- Slot X (X = A or B) has two states, EMPTY and FULL.
  - EMPTY to FULL: on accept of a word with sel=X.
  - FULL to EMPTY: on x_valid & x_ready with no new accept for X.
  - FULL to FULL: on simultaneous drain and accept for X. The new word replaces the old one and x_valid stays 1.
- in_ready = (in_sel==0) ? (~a_valid | a_ready) : (~b_valid | b_ready).
  - in_ready depends only on the selected slot; a stalled B never blocks a word bound for A.
  - Combinational path: a_ready/b_ready to in_ready. This path is accepted by design.
- Accept occurs when in_valid & in_ready. The word is loaded into the selected slot at that edge.
- Latency: a word accepted at edge N is visible on x_valid/x_data after edge N; the earliest drain is the cycle following edge N.
- Throughput: one word per cycle, sustained, when the selected destination holds ready=1.
- x_data stays stable while x_valid=1 and x_ready=0. The source's in_data/in_sel may change freely while in_ready=0.
- The slot not selected keeps its state; only its drain is processed.
- Ordering: order is preserved within each destination. There is no ordering guarantee between A and B.
- Counters: cnt_X increments by 1 on each x_valid & x_ready. It wraps from 2^CNT_W-1 to 0 with no saturation and no flag.
- x_ready asserted while x_valid=0 has no effect.
- in_valid=0 produces no accept, regardless of in_sel.
- in_sel is a don't-care for state when in_valid=0, but it still selects which slot drives in_ready.

Decomposition:
- Shared package/header holds two constants: SEL_A=1'b0 and SEL_B=1'b1.
- Natural sub-module: demux_slot.
  - One-entry register slice with load/valid/ready/data and its transfer counter.
  - Instantiated twice.
- Top level contains only the select decode and the in_ready mux.

Test Plan:
1. Reset then idle: assert rst for 2 cycles with in_valid=1 -> a_valid=b_valid=0, cnt_a=cnt_b=0, in_ready=1, no word delivered.
2. Alternating steer: a_ready=b_ready=1; send 0x11111111 sel=0, 0x22222222 sel=1, 0x33333333 sel=0 on consecutive cycles -> A receives 0x11111111 then 0x33333333; B receives 0x22222222; each word appears one cycle after accept; final cnt_a=2, cnt_b=1.
3. Independent back-pressure: b_ready=0; send 0xDEADBEEF sel=1, then 0xCAFEF00D sel=1, then 0x00000005 sel=0 -> b_valid=1 with b_data held at 0xDEADBEEF; in_ready=0 while 0xCAFEF00D is presented; once the source switches to the sel=0 word, in_ready=1 and A receives 0x00000005. Releasing b_ready then lets 0xCAFEF00D through.
4. Full-throughput drain-and-refill: a_ready=1; stream 8 words 0 to 7 with sel=0 back-to-back -> in_ready held at 1, a_valid held at 1 from cycle 1 to 8, data in order, cnt_a=8.
5. Counter wrap: CNT_W=4; deliver 17 words to A -> cnt_a=1; cnt_b=0.
6. Reset mid-operation: with A FULL (0xFFFFFFFF) and a_ready=0, assert rst one cycle -> a_valid=0, a_data=0, cnt_a=0; the next accepted word is delivered normally.
